// File: rtl/expr_gen.sv
// expr_gen: emits a digit/operator ASCII expression one character per clock
// and evaluates it with '*' binding tighter than '+', modulo 2^W.
// Ports: clk/clr (async active-high reset); start, num_terms, digits, ops
//        (request, captured on acceptance); char/char_valid (character
//        stream); busy, done, err (status pulses); result (expression value).
// Latency: first character one cycle after the accepting edge, 2N cycles
// total including the done cycle. start is only honoured in IDLE or DONE and
// is otherwise dropped, so there is no backpressure on the stream.
module expr_gen #(
  parameter int MAXT = 8,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        num_terms,
  input  logic [4*MAXT-1:0] digits,
  input  logic [MAXT-2:0]   ops,
  output logic [7:0]        char,
  output logic              char_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [W-1:0]      result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_OP    = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [3:0] MAXT_L = 4'(MAXT);

  // r_state names the character class currently on the outputs, and r_k
  // the term index of that character.
  state_t            r_state, w_state;
  logic [3:0]        r_k, w_k;
  logic [3:0]        r_n, w_n;
  logic [4*MAXT-1:0] r_digits, w_digits;
  logic [MAXT-1:0]   r_ops, w_ops;
  logic [W-1:0]      r_sum, w_sum;
  logic [W-1:0]      r_prod, w_prod;
  logic [7:0]        r_char, w_char;
  logic              r_char_valid, w_char_valid;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [W-1:0]      r_result, w_result;

  logic              w_bad_req;
  logic [3:0]        w_k_next;
  logic [3:0]        w_d_next;
  logic [MAXT-1:0]   w_ops_sh;
  logic              w_op_mul;

  function automatic logic [3:0] digit_at(input logic [4*MAXT-1:0] v,
                                          input logic [3:0] idx);
    logic [4*MAXT-1:0] s;
    s = v >> {idx, 2'b00};
    return s[3:0];
  endfunction

  // Request validation looks only at the digits that will actually be used.
  always_comb begin
    w_bad_req = (num_terms == 4'd0) || (num_terms > MAXT_L);
    for (int i = 0; i < MAXT; i++) begin
      if ((4'(i) < num_terms) && (digits[4*i +: 4] > 4'd9)) begin
        w_bad_req = 1'b1;
      end
    end
  end

  assign w_k_next = r_k + 4'd1;
  assign w_d_next = digit_at(r_digits, w_k_next);
  assign w_ops_sh = r_ops >> r_k;
  assign w_op_mul = w_ops_sh[0];

  // Each digit is folded into prod as it is emitted; a '+' closes the
  // current product term into sum. The first digit is folded at acceptance.
  always_comb begin
    w_state      = r_state;
    w_k          = r_k;
    w_n          = r_n;
    w_digits     = r_digits;
    w_ops        = r_ops;
    w_sum        = r_sum;
    w_prod       = r_prod;
    w_char       = r_char;
    w_char_valid = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_result     = r_result;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        if (start) begin
          if (w_bad_req) begin
            w_state = S_FAIL;
            w_err   = 1'b1;
          end else begin
            w_state      = S_DIGIT;
            w_k          = 4'd0;
            w_n          = num_terms;
            w_digits     = digits;
            w_ops        = {1'b0, ops};
            w_sum        = '0;
            w_prod       = W'(digits[3:0]);
            w_char       = 8'h30 + {4'h0, digits[3:0]};
            w_char_valid = 1'b1;
            w_busy       = 1'b1;
          end
        end
      end

      S_DIGIT: begin
        if (r_k == r_n - 4'd1) begin
          w_state  = S_DONE;
          w_done   = 1'b1;
          w_result = r_sum + r_prod;
        end else begin
          w_state      = S_OP;
          w_char       = w_op_mul ? 8'h2A : 8'h2B;
          w_char_valid = 1'b1;
          w_busy       = 1'b1;
          if (!w_op_mul) begin
            w_sum  = r_sum + r_prod;
            w_prod = W'(1);
          end
        end
      end

      S_OP: begin
        w_state      = S_DIGIT;
        w_k          = w_k_next;
        w_prod       = r_prod * W'(w_d_next);
        w_char       = 8'h30 + {4'h0, w_d_next};
        w_char_valid = 1'b1;
        w_busy       = 1'b1;
      end

      S_FAIL: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_n          <= '0;
      r_digits     <= '0;
      r_ops        <= '0;
      r_sum        <= '0;
      r_prod       <= '0;
      r_char       <= '0;
      r_char_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= '0;
    end else begin
      r_state      <= w_state;
      r_k          <= w_k;
      r_n          <= w_n;
      r_digits     <= w_digits;
      r_ops        <= w_ops;
      r_sum        <= w_sum;
      r_prod       <= w_prod;
      r_char       <= w_char;
      r_char_valid <= w_char_valid;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
      r_result     <= w_result;
    end
  end

  assign char       = r_char;
  assign char_valid = r_char_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign result     = r_result;

endmodule

// File: tb/tb_expr_gen.sv
// Bench for expr_gen: directed streams with literal expectations plus a
// randomized phase, all tracked cycle by cycle by a transaction-level model.
module tb_expr_gen;
  localparam int MAXT = 8;
  localparam int W    = 16;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  num_terms;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic [7:0]  char;
  logic        char_valid, busy, done, err;
  logic [15:0] result;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  expr_gen #(.MAXT(MAXT), .W(W)) dut (
    .clk(clk), .clr(clr), .start(start), .num_terms(num_terms),
    .digits(digits), .ops(ops), .char(char), .char_valid(char_valid),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        vld;
    logic        dn;
    logic        er;
    logic [7:0]  ch;
    logic [15:0] res;
  } rec_t;

  rec_t q[$];
  rec_t m_cur = '0;

  function automatic logic [15:0] eval_expr(int n, logic [31:0] d, logic [6:0] o);
    longint sum = 0;
    longint prod = 1;
    logic [63:0] s;
    for (int i = 0; i < n; i++) begin
      prod = prod * longint'(d[4*i +: 4]);
      if (i == n - 1 || o[i] == 1'b0) begin
        sum  = sum + prod;
        prod = 1;
      end
    end
    s = 64'(sum);
    return s[15:0];
  endfunction

  // On acceptance the whole expected future (characters then done, or one
  // err cycle) is queued; each edge shows the next queued cycle or idles.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      q.delete();
      m_cur = '0;
    end else begin
      if (start && q.size() == 0 && !m_cur.er) begin
        bit   bad;
        int   n;
        rec_t r;
        n   = int'(num_terms);
        bad = (n == 0) || (n > MAXT);
        for (int i = 0; i < MAXT; i++)
          if (i < n && digits[4*i +: 4] > 4'd9) bad = 1'b1;
        r = '0;
        if (bad) begin
          r.er = 1'b1;
          q.push_back(r);
        end else begin
          for (int j = 0; j < 2*n - 1; j++) begin
            r     = '0;
            r.vld = 1'b1;
            if (j % 2 == 0) r.ch = 8'h30 + {4'h0, digits[4*(j/2) +: 4]};
            else            r.ch = ops[j/2] ? 8'h2A : 8'h2B;
            q.push_back(r);
          end
          r     = '0;
          r.dn  = 1'b1;
          r.res = eval_expr(n, digits, ops);
          q.push_back(r);
        end
      end
      if (q.size() > 0) begin
        rec_t r;
        r = q.pop_front();
        m_cur.vld = r.vld;
        m_cur.dn  = r.dn;
        m_cur.er  = r.er;
        if (r.vld) m_cur.ch  = r.ch;
        if (r.dn)  m_cur.res = r.res;
      end else begin
        m_cur.vld = 1'b0;
        m_cur.dn  = 1'b0;
        m_cur.er  = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("cycle", {4'h0, char, char_valid, busy, done, err, result},
          {4'h0, m_cur.ch, m_cur.vld, m_cur.vld, m_cur.dn, m_cur.er, m_cur.res});
  end

  // ---------------- directed helpers ----------------
  logic [7:0] cap_q[$];

  task automatic run(input int n, input logic [31:0] d, input logic [6:0] o,
                     input bit noisy, output int first, output int total,
                     output logic [15:0] res);
    num_terms = 4'(n); digits = d; ops = o; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cap_q.delete();
    first = -1; total = 0; res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (char_valid) begin
        cap_q.push_back(char);
        if (first < 0) first = c;
      end
      if (done) begin
        total = c;
        res   = result;
        break;
      end
      if (noisy && busy) begin
        start     = 1'($urandom_range(0, 1));
        num_terms = 4'($urandom_range(1, 8));
        digits    = $urandom;
        ops       = 7'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (total == 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_stream(input string exp);
    check("stream_len", cap_q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < cap_q.size(); i++)
      check("stream_char", {24'h0, cap_q[i]}, {24'h0, exp[i]});
  endtask

  task automatic reject(input int n, input logic [31:0] d);
    int n_err = 0;
    int n_vld = 0;
    num_terms = 4'(n); digits = d; ops = '0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (err) n_err++;
      if (char_valid) n_vld++;
    end
    check("rej_err_pulses", n_err, 1);
    check("rej_chars", n_vld, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first, total, extra;
    logic [15:0] res;
    bit last_err;

    clr = 1'b1; start = 1'b0; num_terms = '0; digits = '0; ops = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {char, char_valid, busy, done, err, result}, 0);
    clr = 1'b0;
    @(negedge clk);

    run(1, 32'h7, 7'h0, 0, first, total, res);
    check_stream("7");
    check("n1_first", first, 1);
    check("n1_total", total, 2);
    check("n1_result", res, 16'd7);

    run(3, 32'h432, 7'b0000010, 0, first, total, res);
    check_stream("2+3*4");
    check("n3_total", total, 6);
    check("n3_result", res, 16'd14);

    run(8, 32'h99999999, 7'h7F, 0, first, total, res);
    check_stream("9*9*9*9*9*9*9*9");
    check("n8_total", total, 16);
    check("n8_result", res, 16'd55105);
    // started during the DONE cycle just observed
    run(2, 32'h55, 7'h0, 0, first, total, res);
    check_stream("5+5");
    check("b2b_first", first, 1);
    check("b2b_result", res, 16'd10);

    @(negedge clk);
    reject(0, 32'h0);
    check("rej0_result", result, 16'd10);
    reject(2, 32'hA5);
    check("rej_digit_result", result, 16'd10);

    run(5, 32'h54321, 7'b0001010, 1, first, total, res);
    check_stream("1+2*3+4*5");
    check("noisy_result", res, 16'd27);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("noisy_extra_done", extra, 0);

    // abort after the second character
    num_terms = 4'd5; digits = 32'h11111; ops = '0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_char1", char, 8'h2B);
    #1 clr = 1'b1;
    #1 check("abort_outputs", {char, char_valid, busy, done, err, result}, 0);
    @(posedge clk);
    @(negedge clk) clr = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || char_valid) extra++;
    end
    check("abort_quiet", extra, 0);
    run(2, 32'h21, 7'b1, 0, first, total, res);
    check_stream("1*2");
    check("post_clr_result", res, 16'd2);

    // randomized phase, checked by the model every cycle
    last_err = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int n;
      int wait_c;
      logic [31:0] d;
      bit seen;
      if (last_err || $urandom_range(0, 2) == 0) @(negedge clk);
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8));
      d = 0;
      for (int i = 0; i < 8; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) d[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      num_terms = 4'(n); digits = d; ops = 7'($urandom); start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      seen = 1'b0; last_err = 1'b0;
      wait_c = 0;
      while (!seen && wait_c < 30) begin
        @(negedge clk);
        wait_c++;
        if (done) seen = 1'b1;
        if (err) begin seen = 1'b1; last_err = 1'b1; end
        start = (!seen && busy && $urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      if (!seen) check("rand_timeout", 0, 1);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
